// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response handshake bundle for alu_mc.
interface alu_mc_if #(parameter int XLEN = 64);
    logic in_valid, in_ready, out_valid, out_ready, zero_flag;
    logic [XLEN-1:0] in1, in2, alu_result;
    logic [3:0] alu_control;
    modport master(output in_valid, in1, in2, alu_control, out_ready, input in_ready, out_valid, alu_result, zero_flag);
    modport slave(input in_valid, in1, in2, alu_control, out_ready, output in_ready, out_valid, alu_result, zero_flag);
endinterface

// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU; single-cycle logic ops, iterative shift-add multiply and restoring divide.
module alu_mc #(
    parameter int XLEN = 64,
    parameter int SHW = $clog2(XLEN)
) (
    input logic clk,
    input logic rst_n,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [SHW:0] LAST = (SHW+1)'(XLEN-1);
    state_t state, state_nx;
    logic [SHW:0] cnt;
    logic [XLEN-1:0] acc, opa, opb, res, quick, acc_nx, opb_nx, res_nx;
    logic [XLEN:0] trial;
    logic [SHW-1:0] sh;
    logic op_mul, op_rem, zf, accept, iter, last;
    assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
    assign bus.out_valid = state == DONE;
    assign bus.alu_result = res;
    assign bus.zero_flag = zf;
    assign accept = bus.in_valid && bus.in_ready;
    assign sh = bus.in2[SHW-1:0];
    assign last = cnt == LAST;
    // Division by zero resolves in one cycle, so only a nonzero divisor iterates
    assign iter = bus.alu_control == 4'b0110 || ((bus.alu_control == 4'b1011 || bus.alu_control == 4'b1100) && |bus.in2);
    always_comb begin
        quick = '0;
        case (bus.alu_control)
            4'b0000: quick = bus.in1 & bus.in2;
            4'b0001: quick = bus.in1 | bus.in2;
            4'b0010: quick = bus.in1 + bus.in2;
            4'b0011: quick = bus.in1 << sh;
            4'b0100: quick = bus.in1 - bus.in2;
            4'b0101: quick = bus.in1 >> sh;
            4'b0111: quick = bus.in1 ^ bus.in2;
            4'b1000: quick = {{(XLEN-1){1'b0}}, bus.in1 < bus.in2};
            4'b1001: quick = {{(XLEN-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
            4'b1010: quick = $unsigned($signed(bus.in1) >>> sh);
            4'b1011: quick = '1;
            4'b1100: quick = bus.in1;
            default: quick = '0;
        endcase
    end
    // Multiply: acc += opa when opb[0], opa<<1, opb>>1. Divide: acc is remainder, opb shifts dividend out and quotient in.
    always_comb begin
        trial = {acc, opb[XLEN-1]} - {1'b0, opa};
        acc_nx = op_mul ? acc + (opb[0] ? opa : '0) : (trial[XLEN] ? {acc[XLEN-2:0], opb[XLEN-1]} : trial[XLEN-1:0]);
        opb_nx = op_mul ? opb >> 1 : {opb[XLEN-2:0], ~trial[XLEN]};
        res_nx = op_mul || op_rem ? acc_nx : opb_nx;
    end
    always_comb begin
        state_nx = state;
        if (accept) state_nx = iter ? BUSY : DONE;
        else if (state == BUSY && last) state_nx = DONE;
        else if (state == DONE && bus.out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            opa <= '0;
            opb <= '0;
            res <= '0;
            zf <= 1'b0;
            op_mul <= 1'b0;
            op_rem <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            acc <= '0;
            op_mul <= bus.alu_control == 4'b0110;
            op_rem <= bus.alu_control == 4'b1100;
            opa <= bus.alu_control == 4'b0110 ? bus.in1 : bus.in2;
            opb <= bus.alu_control == 4'b0110 ? bus.in2 : bus.in1;
            if (!iter) begin
                res <= quick;
                zf <= quick == '0;
            end
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nx;
            opa <= op_mul ? opa << 1 : opa;
            opb <= opb_nx;
            if (last) begin
                res <= res_nx;
                zf <= res_nx == '0;
            end
        end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, random model compare and handshake/reset sequences for alu_mc at XLEN 64 and 8.
module tb_alu_mc;
    logic clk, rst_n;
    int total = 0, bad = 0;
    alu_mc_if #(.XLEN(64)) b64();
    alu_mc_if #(.XLEN(8)) b8();
    alu_mc #(.XLEN(64)) u64(.clk(clk), .rst_n(rst_n), .bus(b64));
    alu_mc #(.XLEN(8)) u8(.clk(clk), .rst_n(rst_n), .bus(b8));
    initial clk = 0;
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0] op;
        logic [63:0] a, b, res;
        int lat;
    } vec_t;
    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, b, res, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
        return v;
    endfunction
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, b);
        int unsigned s = int'(b[5:0]);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a << s;
            4'd4: return a - b;
            4'd5: return a >> s;
            4'd6: return a * b;
            4'd7: return a ^ b;
            4'd8: return (a < b) ? 64'd1 : 64'd0;
            4'd9: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd10: return $signed(a) >>> s;
            4'd11: return b == 0 ? '1 : a / b;
            4'd12: return b == 0 ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction
    task automatic chk(input string nm, input logic [63:0] got, exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask
    task automatic do_op(input logic [3:0] op, input logic [63:0] a, b, output logic [63:0] r, output logic z, output int lat, output int lo);
        int w = 0;
        while (!b64.in_ready && w < 200) begin @(negedge clk); w++; end
        b64.in_valid = 1; b64.alu_control = op; b64.in1 = a; b64.in2 = b;
        @(negedge clk);
        b64.in_valid = 0; b64.in1 = {$urandom, $urandom}; b64.in2 = {$urandom, $urandom}; b64.alu_control = 4'($urandom);
        lat = 1; lo = 0;
        while (!b64.out_valid && lat < 200) begin
            if (!b64.in_ready) lo++;
            @(negedge clk);
            lat++;
        end
        r = b64.alu_result; z = b64.zero_flag;
    endtask
    task automatic do_op8(input logic [3:0] op, input logic [7:0] a, b, output logic [7:0] r, output logic z, output int lat);
        int w = 0;
        while (!b8.in_ready && w < 50) begin @(negedge clk); w++; end
        b8.in_valid = 1; b8.alu_control = op; b8.in1 = a; b8.in2 = b;
        @(negedge clk);
        b8.in_valid = 0; b8.in1 = 8'($urandom); b8.in2 = 8'($urandom);
        lat = 1;
        while (!b8.out_valid && lat < 50) begin @(negedge clk); lat++; end
        r = b8.alu_result; z = b8.zero_flag;
    endtask
    initial begin
        vec_t tbl[$];
        logic [63:0] r, a, b, exp, held;
        logic [7:0] r8;
        logic [3:0] op;
        logic z;
        int lat, lo, seen;
        b64.in_valid = 0; b64.out_ready = 1; b64.in1 = 0; b64.in2 = 0; b64.alu_control = 0;
        b8.in_valid = 0; b8.out_ready = 1; b8.in1 = 0; b8.in2 = 0; b8.alu_control = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("rst in_ready", 64'(b64.in_ready), 64'd1);
        chk("rst out_valid", 64'(b64.out_valid), 64'd0);
        chk("rst result", b64.alu_result, 64'd0);
        chk("rst zero_flag", 64'(b64.zero_flag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("post-rst in_ready", 64'(b64.in_ready), 64'd1);
        @(negedge clk);
        tbl.push_back(mk(4'b0010, '1, 64'd1, 64'd0, 1));
        tbl.push_back(mk(4'b0110, 64'h1_0000_0003, 64'd5, 64'h5_0000_000F, 65));
        tbl.push_back(mk(4'b1011, 64'd100, 64'd7, 64'd14, 65));
        tbl.push_back(mk(4'b1100, 64'd100, 64'd7, 64'd2, 65));
        tbl.push_back(mk(4'b1011, 64'd100, 64'd0, '1, 1));
        tbl.push_back(mk(4'b1100, 64'd100, 64'd0, 64'd100, 1));
        tbl.push_back(mk(4'b1001, '1, 64'd1, 64'd1, 1));
        tbl.push_back(mk(4'b1000, '1, 64'd1, 64'd0, 1));
        tbl.push_back(mk(4'b1010, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1));
        tbl.push_back(mk(4'b0000, 64'hFF00, 64'h0FF0, 64'h0F00, 1));
        tbl.push_back(mk(4'b0001, 64'hFF00, 64'h0FF0, 64'hFFF0, 1));
        tbl.push_back(mk(4'b0100, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1));
        tbl.push_back(mk(4'b0011, 64'd1, 64'h41, 64'd2, 1));
        tbl.push_back(mk(4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1));
        tbl.push_back(mk(4'b0111, 64'h1234, 64'h1234, 64'd0, 1));
        tbl.push_back(mk(4'b1101, 64'd9, 64'd3, 64'd0, 1));
        tbl.push_back(mk(4'b1111, 64'd9, 64'd3, 64'd0, 1));
        tbl.push_back(mk(4'b0110, '1, '1, 64'd1, 65));
        tbl.push_back(mk(4'b1011, '1, 64'd1, '1, 65));
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, lat, lo);
            chk($sformatf("vec%0d result", i), r, tbl[i].res);
            chk($sformatf("vec%0d zero_flag", i), 64'(z), 64'(tbl[i].res == 0));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d busy cycles", i), 64'(lo), 64'(tbl[i].lat - 1));
        end
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = 0;
                1, 2: b = 64'($urandom_range(1, 300));
                default: b = {$urandom, $urandom};
            endcase
            exp = model(op, a, b);
            do_op(op, a, b, r, z, lat, lo);
            chk($sformatf("rnd%0d op%0d result", i, op), r, exp);
            chk($sformatf("rnd%0d zero_flag", i), 64'(z), 64'(exp == 0));
            chk($sformatf("rnd%0d latency", i), 64'(lat), (op == 6 || ((op == 11 || op == 12) && b != 0)) ? 64'd65 : 64'd1);
        end
        @(negedge clk);
        b64.out_ready = 0; b64.in_valid = 1; b64.alu_control = 4'b0111;
        b64.in1 = 64'hF0F0_F0F0_F0F0_F0F0; b64.in2 = 64'h0FF0_0FF0_0FF0_0FF0;
        @(negedge clk);
        b64.in_valid = 0;
        held = 64'hFF00_FF00_FF00_FF00;
        chk("bp out_valid", 64'(b64.out_valid), 64'd1);
        chk("bp result", b64.alu_result, held);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d result", i), b64.alu_result, held);
            chk($sformatf("bp hold%0d in_ready", i), 64'(b64.in_ready), 64'd0);
            chk($sformatf("bp hold%0d out_valid", i), 64'(b64.out_valid), 64'd1);
        end
        b64.out_ready = 1; b64.in_valid = 1; b64.alu_control = 4'b0010; b64.in1 = 64'd3; b64.in2 = 64'd4;
        #1 chk("bp release in_ready", 64'(b64.in_ready), 64'd1);
        @(negedge clk);
        b64.in_valid = 0;
        chk("b2b out_valid", 64'(b64.out_valid), 64'd1);
        chk("b2b result", b64.alu_result, 64'd7);
        @(negedge clk);
        chk("b2b drained", 64'(b64.out_valid), 64'd0);
        b64.in_valid = 1; b64.alu_control = 4'b0110; b64.in1 = 64'd11; b64.in2 = 64'd13;
        @(negedge clk);
        b64.in_valid = 0;
        repeat (29) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort out_valid", 64'(b64.out_valid), 64'd0);
        chk("abort in_ready", 64'(b64.in_ready), 64'd1);
        chk("abort result", b64.alu_result, 64'd0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (b64.out_valid) seen++;
        end
        chk("abort no result", 64'(seen), 64'd0);
        do_op(4'b0110, 64'd3, 64'd4, r, z, lat, lo);
        chk("after abort result", r, 64'd12);
        chk("after abort latency", 64'(lat), 64'd65);
        do_op8(4'b0010, 8'hFF, 8'h01, r8, z, lat);
        chk("x8 add result", 64'(r8), 64'd0);
        chk("x8 add zero_flag", 64'(z), 64'd1);
        chk("x8 add latency", 64'(lat), 64'd1);
        do_op8(4'b0110, 8'd15, 8'd17, r8, z, lat);
        chk("x8 mul result", 64'(r8), 64'd255);
        chk("x8 mul latency", 64'(lat), 64'd9);
        do_op8(4'b1011, 8'd200, 8'd7, r8, z, lat);
        chk("x8 divu result", 64'(r8), 64'd28);
        do_op8(4'b1100, 8'd200, 8'd7, r8, z, lat);
        chk("x8 remu result", 64'(r8), 64'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter XLEN, default 64, operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL provide parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in1  input  XLEN  operand A.
REQ-008 in2  input  XLEN  operand B.
REQ-009 alu_control  input  4  operation select.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 alu_result  output  XLEN  registered result.
REQ-013 zero_flag  output  1  registered; 1 iff alu_result == 0.

Function
REQ-014 Accept occurs on a rising edge with in_valid && in_ready; operands and alu_control are captured at accept and ignored otherwise.
REQ-015 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0111 XOR, 1000 SLTU, 1001 SLT (signed), 1010 SRA, 0110 MUL (low XLEN bits of product), 1011 DIVU, 1100 REMU; all other codes produce 0.
REQ-016 Add/sub/multiply wrap modulo 2^XLEN; shifts use in2[SHW-1:0] only; SLT/SLTU return 1 or 0, zero-extended.
REQ-017 State machine: IDLE, BUSY, DONE; reset state IDLE.
REQ-018 Single-cycle ops (all except MUL/DIVU/REMU): IDLE -> DONE at accept; out_valid asserted the cycle after accept (latency 1).
REQ-019 MUL: IDLE -> BUSY at accept; iterative shift-add, one partial-product step per cycle, a step counter of width SHW+1 counting XLEN steps; BUSY -> DONE on the edge completing step XLEN; latency XLEN+1 cycles.
REQ-020 DIVU/REMU: restoring division, one quotient bit per cycle, same counter and latency as MUL.
REQ-021 Divide by zero (in2 == 0 at accept): no BUSY; DONE next cycle; DIVU gives all ones, REMU gives in1.
REQ-022 in_ready = (state == IDLE) || (state == DONE && out_ready); in_ready is 0 throughout BUSY.
REQ-023 In DONE with out_ready = 0: alu_result, zero_flag and out_valid SHALL hold stable.
REQ-024 DONE with out_ready = 1 and no new accept -> IDLE, out_valid deasserts next cycle.
REQ-025 DONE with out_ready = 1 and simultaneous accept -> behaves as an accept from IDLE (back-to-back, no bubble for single-cycle ops).
REQ-026 zero_flag SHALL update in the same cycle as alu_result and never lag it.
REQ-027 in_valid/operand changes while BUSY SHALL NOT affect the in-flight result.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid 0, alu_result 0, zero_flag 0 and the step counter 0, without waiting for clk.
REQ-029 Reset during BUSY SHALL abort the operation; no result is emitted after release.
REQ-030 in_ready SHALL read 1 while in reset and on the first cycle after release.

Verification
REQ-031 XLEN=64, ADD in1=0xFFFF_FFFF_FFFF_FFFF, in2=1, out_ready=1 -> out_valid one cycle after accept, alu_result 0, zero_flag 1.
REQ-032 XLEN=64, MUL in1=0x1_0000_0003, in2=5 -> in_ready 0 for 64 cycles, out_valid at cycle 65, alu_result 0x5_0000_000F, zero_flag 0.
REQ-033 DIVU in1=100, in2=7 -> 14; REMU same operands -> 2; DIVU in2=0 -> 0xFFFF_FFFF_FFFF_FFFF one cycle after accept; REMU in1=100, in2=0 -> 100.
REQ-034 SLT in1=-1, in2=1 -> 1; SLTU same operands -> 0; SRA in1=0x8000_0000_0000_0000, in2=0x43 -> 0xF000_0000_0000_0000.
REQ-035 Backpressure: single-cycle XOR result held with out_ready=0 for 5 cycles -> alu_result stable and in_ready 0; then out_ready=1 with new request in_valid=1 -> accept that cycle, new result next cycle.
REQ-036 Assert rst_n low at step 30 of a MUL -> out_valid 0 immediately, no out_valid after release, next request completes normally; repeat REQ-031 at XLEN=8 (0xFF+1 -> 0, zero_flag 1).
